// File: rtl/lusdos_nios_dct_packer.sv
// Packs 2-bit trace atoms into 15-atom frames with a one-deep output register,
// flush/overflow handling, and a RUN -> ENDING -> ENDED session state machine.
module lusdos_nios_dct_packer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        atom_valid,
    input  logic [1:0]  atom_data,
    input  logic        flush,
    input  logic        stop,
    input  logic        frame_ready,
    output logic [29:0] dct_buffer,
    output logic [3:0]  dct_count,
    output logic        frame_valid,
    output logic [29:0] frame_data,
    output logic [3:0]  frame_count,
    output logic        overflow,
    output logic        test_ending,
    output logic        test_has_ended
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        ENDING = 2'd1,
        ENDED  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [29:0] dctBuffer_q, dctBuffer_d;
    logic [3:0]  dctCount_q, dctCount_d;
    logic        frameValid_q, frameValid_d;
    logic [29:0] frameData_q, frameData_d;
    logic [3:0]  frameCount_q, frameCount_d;
    logic        overflow_q, overflow_d;
    logic        flushPend_q, flushPend_d;
    logic        testEnding_q, testEnding_d;
    logic        testEnded_q, testEnded_d;

    logic outFree;
    logic bufNotEmpty;
    logic bufFull;
    logic flushIn;
    logic flushActive;
    logic atomIn;
    logic transfer;

    // A transfer empties the packing buffer into the output register; an atom
    // arriving on that same edge becomes the first atom of the next frame.
    always_comb begin
        outFree     = !frameValid_q || frame_ready;
        bufNotEmpty = (dctCount_q != 4'd0);
        bufFull     = (dctCount_q == 4'd15);
        flushIn     = flush && (state_q != ENDED);
        flushActive = (flushIn || flushPend_q) && bufNotEmpty;
        atomIn      = atom_valid && (state_q == RUN);
        transfer    = outFree && (bufFull || flushActive ||
                                  ((state_q == ENDING) && bufNotEmpty));

        dctBuffer_d  = dctBuffer_q;
        dctCount_d   = dctCount_q;
        frameValid_d = frameValid_q;
        frameData_d  = frameData_q;
        frameCount_d = frameCount_q;
        overflow_d   = overflow_q;
        flushPend_d  = flushPend_q;
        state_d      = state_q;

        if (transfer) begin
            frameData_d  = dctBuffer_q;
            frameCount_d = dctCount_q;
            frameValid_d = 1'b1;
            flushPend_d  = 1'b0;
            if (atomIn) begin
                dctBuffer_d = {28'b0, atom_data};
                dctCount_d  = 4'd1;
            end else begin
                dctBuffer_d = 30'b0;
                dctCount_d  = 4'd0;
            end
        end else begin
            if (frameValid_q && frame_ready) begin
                frameValid_d = 1'b0;
            end
            if (atomIn) begin
                if (bufFull) begin
                    overflow_d = 1'b1;
                end else begin
                    dctBuffer_d = {dctBuffer_q[27:0], atom_data};
                    dctCount_d  = dctCount_q + 4'd1;
                end
            end
            // Repeated flushes while one is pending collapse into that one.
            if (flushIn && bufNotEmpty) begin
                flushPend_d = 1'b1;
            end
        end

        case (state_q)
            RUN: begin
                if (stop) begin
                    state_d = ENDING;
                end
            end
            ENDING: begin
                if (!bufNotEmpty && !frameValid_q) begin
                    state_d = ENDED;
                end
            end
            ENDED: begin
                state_d = ENDED;
            end
            default: begin
                state_d = RUN;
            end
        endcase

        testEnding_d = (state_d == ENDING);
        testEnded_d  = (state_d == ENDED);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= RUN;
            dctBuffer_q  <= 30'b0;
            dctCount_q   <= 4'd0;
            frameValid_q <= 1'b0;
            frameData_q  <= 30'b0;
            frameCount_q <= 4'd0;
            overflow_q   <= 1'b0;
            flushPend_q  <= 1'b0;
            testEnding_q <= 1'b0;
            testEnded_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            dctBuffer_q  <= dctBuffer_d;
            dctCount_q   <= dctCount_d;
            frameValid_q <= frameValid_d;
            frameData_q  <= frameData_d;
            frameCount_q <= frameCount_d;
            overflow_q   <= overflow_d;
            flushPend_q  <= flushPend_d;
            testEnding_q <= testEnding_d;
            testEnded_q  <= testEnded_d;
        end
    end

    assign dct_buffer     = dctBuffer_q;
    assign dct_count      = dctCount_q;
    assign frame_valid    = frameValid_q;
    assign frame_data     = frameData_q;
    assign frame_count    = frameCount_q;
    assign overflow       = overflow_q;
    assign test_ending    = testEnding_q;
    assign test_has_ended = testEnded_q;

endmodule

// File: tb/tb_lusdos_nios_dct_packer.sv
// Directed-vector bench for lusdos_nios_dct_packer: fill, back-to-back, backpressure,
// flush, pending flush, mid-operation reset and stop/drain sequences.
module tb_lusdos_nios_dct_packer;

    logic        clk;
    logic        reset_n;
    logic        atom_valid;
    logic [1:0]  atom_data;
    logic        flush;
    logic        stop;
    logic        frame_ready;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        frame_valid;
    logic [29:0] frame_data;
    logic [3:0]  frame_count;
    logic        overflow;
    logic        test_ending;
    logic        test_has_ended;

    int errorCount;
    int checkCount;

    lusdos_nios_dct_packer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .atom_valid     (atom_valid),
        .atom_data      (atom_data),
        .flush          (flush),
        .stop           (stop),
        .frame_ready    (frame_ready),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .frame_valid    (frame_valid),
        .frame_data     (frame_data),
        .frame_count    (frame_count),
        .overflow       (overflow),
        .test_ending    (test_ending),
        .test_has_ended (test_has_ended)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1ns after a rising edge and are held through the next one.
    task automatic applyStimulus(input logic v, input logic [1:0] d, input logic f,
                                 input logic s, input logic r);
        atom_valid  = v;
        atom_data   = d;
        flush       = f;
        stop        = s;
        frame_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        errorCount  = 0;
        checkCount  = 0;
        reset_n     = 1'b0;
        atom_valid  = 1'b0;
        atom_data   = 2'b00;
        flush       = 1'b0;
        stop        = 1'b0;
        frame_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        checkOutput("rst_buffer", 32'(dct_buffer), 32'h0);
        checkOutput("rst_count", 32'(dct_count), 32'h0);
        checkOutput("rst_fvalid", 32'(frame_valid), 32'h0);
        checkOutput("rst_ovf", 32'(overflow), 32'h0);
        checkOutput("rst_ending", 32'(test_ending), 32'h0);
        checkOutput("rst_ended", 32'(test_has_ended), 32'h0);
        reset_n = 1'b1;

        $display("[TB] fill with 15 atoms of 01");
        for (int i = 0; i < 15; i++) applyStimulus(1'b1, 2'b01, 1'b0, 1'b0, 1'b1);
        checkOutput("fill_count", 32'(dct_count), 32'd15);
        checkOutput("fill_buffer", 32'(dct_buffer), 32'h15555555);
        checkOutput("fill_fvalid_pre", 32'(frame_valid), 32'h0);
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        checkOutput("fill_fvalid", 32'(frame_valid), 32'h1);
        checkOutput("fill_fdata", 32'(frame_data), 32'h15555555);
        checkOutput("fill_fcount", 32'(frame_count), 32'd15);
        checkOutput("fill_count_clr", 32'(dct_count), 32'd0);
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        checkOutput("fill_fvalid_clr", 32'(frame_valid), 32'h0);

        $display("[TB] back-to-back 16 atoms");
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 2'(i), 1'b0, 1'b0, 1'b1);
        checkOutput("b2b_fcount", 32'(frame_count), 32'd15);
        checkOutput("b2b_fdata", 32'(frame_data), 32'h06C6C6C6);
        checkOutput("b2b_fvalid", 32'(frame_valid), 32'h1);
        checkOutput("b2b_count", 32'(dct_count), 32'd1);
        checkOutput("b2b_buffer", 32'(dct_buffer), 32'h3);
        checkOutput("b2b_ovf", 32'(overflow), 32'h0);
        applyStimulus(1'b0, 2'b00, 1'b1, 1'b0, 1'b1);
        checkOutput("b2b_tail_fdata", 32'(frame_data), 32'h3);
        checkOutput("b2b_tail_fcount", 32'(frame_count), 32'd1);
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        checkOutput("b2b_tail_fvalid", 32'(frame_valid), 32'h0);

        $display("[TB] backpressure with 31 atoms");
        for (int i = 0; i < 15; i++) applyStimulus(1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 2'b11, 1'b0, 1'b0, 1'b0);
        checkOutput("bp_hold_fdata", 32'(frame_data), 32'h2AAAAAAA);
        checkOutput("bp_hold_count", 32'(dct_count), 32'd5);
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 2'b11, 1'b0, 1'b0, 1'b0);
        checkOutput("bp_ovf_pre", 32'(overflow), 32'h0);
        applyStimulus(1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
        checkOutput("bp_ovf", 32'(overflow), 32'h1);
        checkOutput("bp_full_count", 32'(dct_count), 32'd15);
        checkOutput("bp_full_buffer", 32'(dct_buffer), 32'h3FFFFFFF);
        checkOutput("bp_stable_fdata", 32'(frame_data), 32'h2AAAAAAA);
        checkOutput("bp_stable_fcount", 32'(frame_count), 32'd15);
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        checkOutput("bp_second_fdata", 32'(frame_data), 32'h3FFFFFFF);
        checkOutput("bp_second_fcount", 32'(frame_count), 32'd15);
        checkOutput("bp_second_count", 32'(dct_count), 32'd0);
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        checkOutput("bp_fvalid_clr", 32'(frame_valid), 32'h0);
        checkOutput("bp_ovf_sticky", 32'(overflow), 32'h1);

        $display("[TB] flush of 3 atoms and of an empty buffer");
        applyStimulus(1'b1, 2'b10, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 2'b01, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 2'b11, 1'b0, 1'b0, 1'b1);
        checkOutput("fl_buffer", 32'(dct_buffer), 32'h27);
        applyStimulus(1'b0, 2'b00, 1'b1, 1'b0, 1'b1);
        checkOutput("fl_fdata", 32'(frame_data), 32'h27);
        checkOutput("fl_fcount", 32'(frame_count), 32'd3);
        checkOutput("fl_fvalid", 32'(frame_valid), 32'h1);
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        checkOutput("fl_fvalid_clr", 32'(frame_valid), 32'h0);
        applyStimulus(1'b0, 2'b00, 1'b1, 1'b0, 1'b1);
        checkOutput("fl_empty_fvalid", 32'(frame_valid), 32'h0);
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        checkOutput("fl_empty_latch", 32'(frame_valid), 32'h0);

        $display("[TB] pending flush under backpressure");
        applyStimulus(1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
        checkOutput("pend_first_fdata", 32'(frame_data), 32'h5);
        applyStimulus(1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
        checkOutput("pend_hold_fdata", 32'(frame_data), 32'h5);
        checkOutput("pend_hold_count", 32'(dct_count), 32'd1);
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        checkOutput("pend_fdata", 32'(frame_data), 32'h2);
        checkOutput("pend_fcount", 32'(frame_count), 32'd1);
        checkOutput("pend_fvalid", 32'(frame_valid), 32'h1);
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        checkOutput("pend_merged", 32'(frame_valid), 32'h0);

        $display("[TB] reset mid-operation");
        applyStimulus(1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) applyStimulus(1'b1, 2'b11, 1'b0, 1'b0, 1'b0);
        checkOutput("mr_pre_count", 32'(dct_count), 32'd7);
        checkOutput("mr_pre_fvalid", 32'(frame_valid), 32'h1);
        atom_valid = 1'b0;
        reset_n    = 1'b0;
        #1;
        checkOutput("mr_buffer", 32'(dct_buffer), 32'h0);
        checkOutput("mr_count", 32'(dct_count), 32'h0);
        checkOutput("mr_fvalid", 32'(frame_valid), 32'h0);
        checkOutput("mr_fdata", 32'(frame_data), 32'h0);
        checkOutput("mr_fcount", 32'(frame_count), 32'h0);
        checkOutput("mr_ovf", 32'(overflow), 32'h0);
        checkOutput("mr_ending", 32'(test_ending), 32'h0);
        checkOutput("mr_ended", 32'(test_has_ended), 32'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        applyStimulus(1'b1, 2'b10, 1'b0, 1'b0, 1'b1);
        checkOutput("mr_first_count", 32'(dct_count), 32'd1);
        checkOutput("mr_first_buffer", 32'(dct_buffer), 32'h2);
        applyStimulus(1'b0, 2'b00, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        checkOutput("mr_drain_fvalid", 32'(frame_valid), 32'h0);

        $display("[TB] stop and drain");
        applyStimulus(1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'b11, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'b01, 1'b0, 1'b1, 1'b0);
        checkOutput("sd_ending", 32'(test_ending), 32'h1);
        checkOutput("sd_count", 32'(dct_count), 32'd5);
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        checkOutput("sd_fvalid", 32'(frame_valid), 32'h1);
        checkOutput("sd_fdata", 32'(frame_data), 32'h1B1);
        checkOutput("sd_fcount", 32'(frame_count), 32'd5);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 2'b11, 1'b0, 1'b0, 1'b0);
            checkOutput("sd_ign_count", 32'(dct_count), 32'd0);
            checkOutput("sd_ign_ovf", 32'(overflow), 32'h0);
            checkOutput("sd_ign_ending", 32'(test_ending), 32'h1);
        end
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        checkOutput("sd_accepted", 32'(frame_valid), 32'h0);
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        checkOutput("sd_ended", 32'(test_has_ended), 32'h1);
        checkOutput("sd_ending_off", 32'(test_ending), 32'h0);
        checkOutput("sd_final_fcount", 32'(frame_count), 32'd5);
        applyStimulus(1'b1, 2'b10, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
        checkOutput("ed_terminal", 32'(test_has_ended), 32'h1);
        checkOutput("ed_count", 32'(dct_count), 32'd0);
        checkOutput("ed_fvalid", 32'(frame_valid), 32'h0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule

// File: doc/lusdos_nios_dct_packer.md
LUSDOS_NIOS_DCT_PACKER -- requirements
Module: lusdos_nios_dct_packer

Interface
REQ-001 The block SHALL have a single clock and a single reset, with these ports:
- clk  input  1  rising-edge clock for all state.
- reset_n  input  1  asynchronous, active-low reset.
REQ-002 The block SHALL have these inputs:
- atom_valid  input  1  a trace atom is present this cycle.
- atom_data  input  2  trace atom code.
- flush  input  1  single-cycle request to emit the partial buffer.
- stop  input  1  single-cycle request to end the trace session.
- frame_ready  input  1  downstream accepts frame this cycle.
REQ-003 The block SHALL have these outputs:
- dct_buffer  output  30  live packing buffer (up to 15 atoms).
- dct_count  output  4  number of atoms in dct_buffer, range 0..15.
- frame_valid  output  1  output frame register holds a frame.
- frame_data  output  30  emitted frame contents.
- frame_count  output  4  atom count of the emitted frame, range 1..15.
- overflow  output  1  sticky flag: an atom was dropped.
- test_ending  output  1  session is draining.
- test_has_ended  output  1  session is complete.

Function
REQ-004 On an accepted atom, the block SHALL shift it in at the LSB: dct_buffer <= {dct_buffer[27:0], atom_data}, and dct_count SHALL increment by 1; latency is 1 cycle.
REQ-005 The output register is free when frame_valid=0 or frame_ready=1 (out_free).
REQ-006 A transfer SHALL occur at a rising edge when out_free=1 and any of these holds:
- dct_count=15
- flush is active or pending and dct_count>0
- state is ENDING and dct_count>0
REQ-007 On a transfer, the block SHALL load frame_data <= dct_buffer and frame_count <= dct_count, and set frame_valid=1 on the next cycle.
REQ-008 A transfer with no same-cycle atom SHALL clear dct_buffer to 0 and dct_count to 0.
REQ-009 An atom arriving in the same cycle as a transfer SHALL be kept: dct_buffer={28'b0, atom_data}, dct_count=1.
REQ-010 When frame_valid=1, frame_ready=1 and no transfer occurs, the block SHALL clear frame_valid on the next cycle.
REQ-011 frame_data and frame_count SHALL hold stable while frame_valid=1 and frame_ready=0.
REQ-012 When dct_count=15, out_free=0 and atom_valid=1, the block SHALL drop the atom, set overflow=1, and leave the buffer unchanged.
REQ-013 overflow SHALL stay set until reset.
REQ-014 flush with dct_count=0 SHALL have no effect and SHALL NOT be latched.
REQ-015 flush with dct_count>0 and out_free=0 SHALL be latched as pending until its transfer occurs; further flushes while pending SHALL merge into that one request.
REQ-016 The state machine SHALL have states RUN, ENDING and ENDED; the reset state is RUN.
REQ-017 In RUN, stop=1 SHALL move the state to ENDING on the next edge; an atom presented in the same cycle as stop SHALL still be accepted.
REQ-018 In ENDING, atom_valid SHALL be ignored; atoms are neither stored nor counted as overflow.
REQ-019 ENDING SHALL move to ENDED when dct_count=0 and frame_valid=0 at the edge (i.e., after the last frame is accepted).
REQ-020 ENDED SHALL be terminal until reset: atoms are ignored, and flush and stop have no effect.
REQ-021 test_ending SHALL be 1 only in ENDING; test_has_ended SHALL be 1 only in ENDED; both SHALL be registered, with no combinational path from inputs.
REQ-022 stop received in ENDING or ENDED SHALL be ignored.
REQ-023 All outputs SHALL be driven directly from registers.

Reset
REQ-024 reset_n=0 SHALL asynchronously force:
- dct_buffer=0, dct_count=0
- frame_valid=0, frame_data=0, frame_count=0
- overflow=0
- flush pending cleared
- state=RUN, test_ending=0, test_has_ended=0
REQ-025 Reset asserted mid-frame or mid-drain SHALL discard all buffered atoms and frames without emitting them.
REQ-026 Reset release SHALL be synchronous to clk; the first atom SHALL be accepted on the first edge with reset_n=1.

Verification
REQ-027 Fill: 15 consecutive atoms of 2'b01 with frame_ready=1 -> dct_count reaches 15, then frame_valid=1 with frame_data=30'h15555555 and frame_count=15; dct_count returns to 0.
REQ-028 Back-to-back: 16 consecutive atoms 0,1,2,3,... with frame_ready=1 -> first frame_count=15; atom 16 (value 3) is retained as dct_count=1, dct_buffer=3; no overflow.
REQ-029 Backpressure: frame_ready=0 and 31 atoms -> first frame holds stable, buffer refills to 15, atom 31 is dropped and overflow=1; raising frame_ready then delivers the second frame with frame_count=15.
REQ-030 Flush: 3 atoms (2,1,3), then flush -> frame_data=30'h27 and frame_count=3; a flush with dct_count=0 produces no frame.
REQ-031 Stop drain: 5 atoms, stop, frame_ready held 0 for 4 cycles -> test_ending=1 throughout; atoms sent during ENDING are ignored; after acceptance, test_has_ended=1 next cycle and frame_count=5.
REQ-032 Reset mid-operation: reset_n pulsed low with frame_valid=1 and dct_count=7 -> all outputs read 0 immediately; state is RUN.
